csel_add_pipe: RTL and testbench

CSEL_ADD_PIPE -- requirements
Module: csel_add_pipe

---
 rtl/csel_add_pipe_pkg.sv | 13 +
 rtl/csel_add_pipe_blk.sv | 20 ++
 rtl/csel_add_pipe.sv | 103 ++++++++++
 tb/tb_csel_add_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_add_pipe_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder.
package csel_add_pipe_pkg;

  localparam int unsigned CSEL_WIDTH = 32;
  localparam int unsigned CSEL_BLK   = 4;
  localparam int unsigned CSEL_GRP   = 2;

  function automatic int unsigned csel_stages(int unsigned width, int unsigned blk,
                                              int unsigned grp);
    return width / (blk * grp);
  endfunction

endpackage

// File: rtl/csel_add_pipe_blk.sv
// BLK-bit carry-select slice: both carry-in cases are summed up front, the real carry picks one.
module csel_blk #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           ci_i,
  output logic [BLK-1:0] s_o,
  output logic           co_o
);

  logic [BLK:0] r0_c;
  logic [BLK:0] r1_c;

  assign r0_c = {1'b0, a_i} + {1'b0, b_i};
  assign r1_c = {1'b0, a_i} + {1'b0, b_i} + (BLK+1)'(1);

  assign {co_o, s_o} = ci_i ? r1_c : r0_c;

endmodule

// File: rtl/csel_add_pipe.sv
// Pipelined carry-select adder/subtractor: one BLK*GRP-bit slice per stage, valid/ready with full-stall.
module csel_add_pipe
  import csel_add_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = CSEL_WIDTH,
  parameter int unsigned BLK   = CSEL_BLK,
  parameter int unsigned GRP   = CSEL_GRP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sumo,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW     = BLK * GRP;
  localparam int unsigned STAGES = csel_stages(WIDTH, BLK, GRP);

  if ((SW == 0) || ((WIDTH % SW) != 0) || (STAGES == 0)) begin : g_bad_cfg
    $error("csel_add_pipe: WIDTH must be a non-zero multiple of BLK*GRP");
  end

  // Rank k feeds stage k; y is stored already inverted for subtraction.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] x_q [STAGES];
  logic [WIDTH-1:0] y_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];

  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];
  logic             stall;
  logic             msb_cin;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [GRP:0]  cc;
    logic [SW-1:0] ss;

    assign cc[0] = c_q[k];

    for (genvar g = 0; g < GRP; g++) begin : g_blk
      csel_blk #(.BLK(BLK)) u_blk (
        .a_i  (x_q[k][k*SW + g*BLK +: BLK]),
        .b_i  (y_q[k][k*SW + g*BLK +: BLK]),
        .ci_i (cc[g]),
        .s_o  (ss[g*BLK +: BLK]),
        .co_o (cc[g+1])
      );
    end

    // Bits above this slice are still zero in s_q, so OR-ing merges the new slice in.
    assign nxt_s[k] = s_q[k] | (WIDTH'(ss) << (k*SW));
    assign nxt_c[k] = cc[GRP];
  end

  assign msb_cin = nxt_s[STAGES-1][WIDTH-1] ^ x_q[STAGES-1][WIDTH-1] ^ y_q[STAGES-1][WIDTH-1];

  // Whole pipeline advances together or holds together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < STAGES; r++) begin
        v_q[r] <= 1'b0;
        x_q[r] <= '0;
        y_q[r] <= '0;
        s_q[r] <= '0;
        c_q[r] <= 1'b0;
      end
      out_valid <= 1'b0;
      sumo      <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      x_q[0] <= x;
      y_q[0] <= sub ? ~y : y;
      s_q[0] <= '0;
      c_q[0] <= sub | cin;
      for (int unsigned r = 1; r < STAGES; r++) begin
        v_q[r] <= v_q[r-1];
        x_q[r] <= x_q[r-1];
        y_q[r] <= y_q[r-1];
        s_q[r] <= nxt_s[r-1];
        c_q[r] <= nxt_c[r-1];
      end
      out_valid <= v_q[STAGES-1];
      sumo      <= nxt_s[STAGES-1];
      cout      <= nxt_c[STAGES-1];
      ovf       <= nxt_c[STAGES-1] ^ msb_cin;
    end
  end

endmodule

// File: tb/tb_csel_add_pipe.sv
// Scoreboard bench: default 32/4/2 instance (directed + random) and a 16/4/1 instance (random).
module tb_csel_add_pipe;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, a_in_valid, a_in_ready, a_cin, a_sub, a_out_valid, a_out_ready;
  logic        a_cout, a_ovf;
  logic [31:0] a_x, a_y, a_sumo;

  logic        rst_b_n, b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready;
  logic        b_cout, b_ovf;
  logic [15:0] b_x, b_y, b_sumo;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  logic b_done = 1'b0;

  csel_add_pipe u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .cin(a_cin), .sub(a_sub),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sumo(a_sumo), .cout(a_cout), .ovf(a_ovf)
  );

  csel_add_pipe #(.WIDTH(16), .BLK(4), .GRP(1)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .cin(b_cin), .sub(b_sub),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sumo(b_sumo), .cout(b_cout), .ovf(b_ovf)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: unsigned and signed arithmetic on plain integers, w-bit wide.
  function automatic exp_t model(logic [31:0] xo, logic [31:0] yo, logic ci, logic sb, int w);
    exp_t   e;
    longint m, xv, yv, sx, sy, u, sr;
    m  = longint'(1) << w;
    xv = longint'(xo);
    yv = longint'(yo);
    sx = (xv >= m / 2) ? xv - m : xv;
    sy = (yv >= m / 2) ? yv - m : yv;
    if (sb) begin
      u   = xv - yv;
      e.c = (xv >= yv);
      sr  = sx - sy;
      if (u < 0) u += m;
    end else begin
      u   = xv + yv + longint'(ci);
      e.c = (u >= m);
      sr  = sx + sy + longint'(ci);
      if (u >= m) u -= m;
    end
    e.s = 32'(u);
    e.o = (sr >= m / 2) || (sr < -(m / 2));
    return e;
  endfunction

  function automatic logic [31:0] rand_op(int w);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom % 8)
      0:       r = 32'd0;
      1:       r = mask;
      2:       r = 32'd1 << (w - 1);
      3:       r = mask >> 1;
      default: r = $urandom & mask;
    endcase
    return r;
  endfunction

  task automatic send_a(logic [31:0] xi, logic [31:0] yi, logic ci, logic sb,
                        logic [31:0] es, logic ec, logic eo);
    int n = 0;
    do begin
      @(negedge clk);
      a_in_valid = 1'b1; a_x = xi; a_y = yi; a_cin = ci; a_sub = sb;
      #1;
      n++;
    end while (!a_in_ready && n < 50);
    if (a_in_ready) qa.push_back('{es, ec, eo});
    else check("a_send_timeout", 64'(n), 64'd0);
  endtask

  task automatic send_a_rand();
    logic [31:0] xi, yi;
    logic        ci, sb;
    exp_t        e;
    xi = rand_op(32); yi = rand_op(32); ci = 1'($urandom); sb = 1'($urandom);
    e  = model(xi, yi, ci, sb, 32);
    send_a(xi, yi, ci, sb, e.s, e.c, e.o);
  endtask

  task automatic idle_a();
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    check("a_drain", 64'(qa.size()), 64'd0);
  endtask

  // Six back-to-back beats; out_ready held low 3 cycles once the first result shows.
  task automatic burst6();
    int   sent = 0;
    int   stall_left = -1;
    int   cyc = 0;
    int   stall_seen = 0;
    exp_t e;
    while ((sent < 6 || qa.size() != 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      a_out_ready = 1'b1;
      if (stall_left < 0 && a_out_valid) stall_left = 3;
      if (stall_left > 0) begin
        a_out_ready = 1'b0;
        stall_left--;
      end
      a_in_valid = (sent < 6);
      a_x = rand_op(32); a_y = rand_op(32); a_cin = 1'($urandom); a_sub = 1'($urandom);
      #1;
      if (!a_out_ready) begin
        stall_seen++;
        check("burst_in_ready_stalled", 64'(a_in_ready), 64'd0);
      end
      if (a_in_valid && a_in_ready) begin
        e = model(a_x, a_y, a_cin, a_sub, 32);
        qa.push_back(e);
        sent++;
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    check("burst_sent", 64'(sent), 64'd6);
    check("burst_stall_cycles", 64'(stall_seen), 64'd3);
    drain_a();
  endtask

  initial begin : mon
    logic        ha, hb;
    logic [34:0] sa;
    logic [18:0] sbv;
    exp_t        e;
    ha = 1'b0; hb = 1'b0; sa = '0; sbv = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_a_n) ha = 1'b0;
      else begin
        if (ha) check("a_hold", 64'({a_out_valid, a_sumo, a_cout, a_ovf}), 64'(sa));
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_spurious actual=%h required=no_beat", a_sumo);
          end else begin
            e = qa.pop_front();
            check("a_result", 64'({a_sumo, a_cout, a_ovf}), 64'({e.s, e.c, e.o}));
          end
        end
        ha = a_out_valid && !a_out_ready;
        sa = {a_out_valid, a_sumo, a_cout, a_ovf};
      end
      if (!rst_b_n) hb = 1'b0;
      else begin
        if (hb) check("b_hold", 64'({b_out_valid, b_sumo, b_cout, b_ovf}), 64'(sbv));
        if (b_out_valid && b_out_ready) begin
          if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_spurious actual=%h required=no_beat", b_sumo);
          end else begin
            e = qb.pop_front();
            check("b_result", 64'({b_sumo, b_cout, b_ovf}), 64'({e.s[15:0], e.c, e.o}));
          end
        end
        hb = b_out_valid && !b_out_ready;
        sbv = {b_out_valid, b_sumo, b_cout, b_ovf};
      end
    end
  end

  initial begin : drv_b
    exp_t e;
    rst_b_n = 1'b0; b_in_valid = 1'b0; b_x = '0; b_y = '0; b_cin = 1'b0; b_sub = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_b_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      b_in_valid  = ($urandom % 4) != 0;
      b_x         = 16'(rand_op(16));
      b_y         = 16'(rand_op(16));
      b_cin       = 1'($urandom);
      b_sub       = 1'($urandom);
      b_out_ready = ($urandom % 3) != 0;
      #1;
      if (b_in_valid && b_in_ready) begin
        e = model(32'(b_x), 32'(b_y), b_cin, b_sub, 16);
        qb.push_back(e);
      end
    end
    @(negedge clk);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    b_done      = 1'b1;
  end

  initial begin : drv_a
    exp_t e;
    int   lat;
    int   n;
    rst_a_n = 1'b0; a_in_valid = 1'b0; a_x = '0; a_y = '0; a_cin = 1'b0; a_sub = 1'b0;
    a_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 64'({a_out_valid, a_sumo, a_cout, a_ovf}), 64'd0);
    check("reset_in_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    rst_a_n = 1'b1;

    send_a(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    send_a(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send_a(32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
    send_a(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send_a(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    send_a(32'd1, 32'd2, 1'b1, 1'b0, 32'd4, 1'b0, 1'b0);
    send_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send_a(32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
    idle_a();
    drain_a();

    burst6();

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a_in_valid  = ($urandom % 4) != 0;
      a_x         = rand_op(32);
      a_y         = rand_op(32);
      a_cin       = 1'($urandom);
      a_sub       = 1'($urandom);
      a_out_ready = ($urandom % 3) != 0;
      #1;
      if (a_in_valid && a_in_ready) begin
        e = model(a_x, a_y, a_cin, a_sub, 32);
        qa.push_back(e);
      end
    end
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    drain_a();

    // Fill and stall, then reset asynchronously mid-cycle.
    a_out_ready = 1'b0;
    send_a_rand();
    send_a_rand();
    idle_a();
    repeat (6) @(negedge clk);
    #1;
    check("prerst_out_valid", 64'(a_out_valid), 64'd1);
    check("prerst_in_ready", 64'(a_in_ready), 64'd0);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({a_out_valid, a_sumo, a_cout, a_ovf}), 64'd0);
    check("midrst_in_ready", 64'(a_in_ready), 64'd1);
    qa.delete();
    repeat (2) @(negedge clk);
    rst_a_n     = 1'b1;
    a_out_ready = 1'b1;

    send_a(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) a_in_valid = 1'b0;
      #1;
      lat++;
    end while (!a_out_valid && lat < 20);
    check("latency_after_reset", 64'(lat - 1), 64'd4);
    drain_a();

    n = 0;
    while (!b_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b_finished", 64'(b_done), 64'd1);
    n = 0;
    while (qb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    check("b_drain", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
